// File: rtl/synapse_pkg.sv
// Shared widths, default timing parameters and the tau_sel decode for the spike synapse.
package synapse_pkg;
  localparam int CURRENT_W          = 8;
  localparam int WEIGHT_W           = 8;
  localparam int TAU_W              = 2;
  localparam int DECAY_PERIOD_DEF   = 16;
  localparam int REFRACT_CYCLES_DEF = 4;

  // Decay shift is tau_sel+1, giving time constants of 1/2 .. 1/16 per tick.
  function automatic logic [2:0] tau_shift(input logic [TAU_W-1:0] tau_sel);
    return 3'(tau_sel) + 3'd1;
  endfunction
endpackage

// File: rtl/synapse_decay_timer.sv
// Free-running decay timer: counts 0..DECAY_PERIOD-1, tick is high while at the last count.
// Latency: tick is combinational from the count; no backpressure.
module synapse_decay_timer
  import synapse_pkg::*;
#(
  parameter int DECAY_PERIOD = DECAY_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECAY_PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/spike_synapse.sv
// Synapse current: adds weight on spike rising edges, decays by shift each tick; refractory via SPIKE_SYNAPSE_REFRACTORY_EN.
// Latency: one cycle from spike event to current/spike_ack update.
// Backpressure: none; events inside the refractory window are dropped, never queued.
module spike_synapse
  import synapse_pkg::*;
#(
  parameter int DECAY_PERIOD   = DECAY_PERIOD_DEF,
  parameter int REFRACT_CYCLES = REFRACT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spike_in,
  input  logic [WEIGHT_W-1:0]  weight_in,
  input  logic                 weight_wr,
  input  logic [TAU_W-1:0]     tau_sel,
  output logic [CURRENT_W-1:0] current,
  output logic                 spike_ack,
  output logic                 sat
);
  logic                 spike_q;
  logic [WEIGHT_W-1:0]  weight;
  logic                 tick;
  logic                 spike_evt;
  logic                 accept;
  logic [CURRENT_W-1:0] decay_amt;
  logic [CURRENT_W-1:0] decayed;
  logic [CURRENT_W:0]   sum;
  logic [CURRENT_W-1:0] current_nxt;
  logic                 sat_nxt;

  if (REFRACT_CYCLES < 1 || REFRACT_CYCLES > 15) begin : g_bad_refract
    $error("REFRACT_CYCLES must be in 1..15");
  end

  synapse_decay_timer #(.DECAY_PERIOD(DECAY_PERIOD)) u_decay_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign spike_evt = spike_in & ~spike_q;

`ifdef SPIKE_SYNAPSE_REFRACTORY_EN
  logic [3:0] refr_cnt;

  assign accept = spike_evt & (refr_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n)               refr_cnt <= 4'd0;
    else if (accept)          refr_cnt <= 4'(REFRACT_CYCLES);
    else if (refr_cnt != 4'd0) refr_cnt <= refr_cnt - 4'd1;
  end
`else
  assign accept = spike_evt;
`endif

  // Decay first, then add the (pre-write) weight, then clamp.
  always_comb begin
    decay_amt = '0;
    decayed   = current;
    if (tick) begin
      decay_amt = current >> tau_shift(tau_sel);
      // Small currents would stall above zero; force a unit step instead.
      if (current != '0 && decay_amt == '0) decay_amt = CURRENT_W'(1);
      decayed = current - decay_amt;
    end
    sum         = {1'b0, decayed} + (accept ? {1'b0, weight} : {(WEIGHT_W + 1){1'b0}});
    sat_nxt     = sum[CURRENT_W];
    current_nxt = sat_nxt ? '1 : sum[CURRENT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q   <= 1'b0;
      weight    <= '0;
      current   <= '0;
      spike_ack <= 1'b0;
      sat       <= 1'b0;
    end else begin
      spike_q   <= spike_in;
      if (weight_wr) weight <= weight_in;
      current   <= current_nxt;
      spike_ack <= accept;
      sat       <= sat_nxt;
    end
  end
endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse with a cycle-level reference model and literal spot checks.
module tb_spike_synapse;
  localparam int DP = 16;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] weight_in = 8'd0;
  logic       weight_wr = 1'b0;
  logic [1:0] tau_sel = 2'd0;
  logic [7:0] current;
  logic       spike_ack;
  logic       sat;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  spike_synapse #(.DECAY_PERIOD(DP), .REFRACT_CYCLES(RC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .weight_in (weight_in),
    .weight_wr (weight_wr),
    .tau_sel   (tau_sel),
    .current   (current),
    .spike_ack (spike_ack),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: cycle index since reset, ticks on index mod DP, refractory
  // expressed as distance from the last accepted event.
  int m_cur, m_w, m_cyc, m_last;
  bit m_prev, m_ack, m_sat;

  always @(posedge clk) begin : model
    bit evt, acc;
    int c, d;
    if (!rst_n) begin
      m_cur = 0; m_w = 0; m_cyc = 0; m_prev = 0;
      m_ack = 0; m_sat = 0; m_last = -1000;
    end else begin
      evt = spike_in && !m_prev;
      acc = evt;
`ifdef SPIKE_SYNAPSE_REFRACTORY_EN
      if (m_cyc - m_last <= RC) acc = 0;
`endif
      c = m_cur;
      if (m_cyc % DP == DP - 1) begin
        d = c >> (int'(tau_sel) + 1);
        if (d == 0 && c > 0) d = 1;
        c = c - d;
      end
      if (acc) begin
        c = c + m_w;
        m_last = m_cyc;
      end
      m_sat = (c > 255);
      if (c > 255) c = 255;
      m_cur = c;
      m_ack = acc;
      if (weight_wr) m_w = int'(weight_in);
      m_prev = spike_in;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_current", int'(current), m_cur);
      check("model_ack", int'(spike_ack), int'(m_ack));
      check("model_sat", int'(sat), int'(m_sat));
    end
  end

  task automatic drive(input logic s, input logic wr, input logic [7:0] w);
    spike_in  = s;
    weight_wr = wr;
    weight_in = w;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    spike_in = 1'b0; weight_wr = 1'b0; weight_in = 8'd0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("reset_current", int'(current), 0);
    check("reset_ack", int'(spike_ack), 0);

    // Accumulate and saturate with weight 100.
    tau_sel = 2'd0;
    drive(1'b0, 1'b1, 8'd100);
    drive(1'b1, 1'b0, 8'd0);
    check("acc_first", int'(current), 100);
    check("acc_first_ack", int'(spike_ack), 1);
    drive(1'b0, 1'b0, 8'd0);
    check("ack_one_cycle", int'(spike_ack), 0);
    drive(1'b1, 1'b0, 8'd0);
    check("acc_second", int'(current), 200);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    check("acc_sat_value", int'(current), 255);
    check("acc_sat_pulse", int'(sat), 1);
    idle(1);
    check("sat_one_cycle", int'(sat), 0);

    // Decay 128 with tau_sel=0, then tau_sel=1.
    do_reset();
    tau_sel = 2'd0;
    drive(1'b0, 1'b1, 8'd128);
    drive(1'b1, 1'b0, 8'd0);
    idle(13);
    check("pre_tick_hold", int'(current), 128);
    idle(1);
    check("decay_tick1", int'(current), 64);
    idle(16);
    check("decay_tick2", int'(current), 32);
    tau_sel = 2'd1;
    idle(16);
    check("decay_tau1", int'(current), 24);

    // Unit-step decay to zero, then hold at zero.
    do_reset();
    tau_sel = 2'd3;
    drive(1'b0, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 8'd0);
    idle(14);
    check("decay_to_zero", int'(current), 0);
    idle(16);
    check("zero_stays", int'(current), 0);

    // Event coinciding with a tick: decay then add.
    do_reset();
    tau_sel = 2'd0;
    drive(1'b0, 1'b1, 8'd128);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd10);
    idle(12);
    drive(1'b1, 1'b0, 8'd0);
    check("tick_and_event", int'(current), 74);
    check("tick_and_event_ack", int'(spike_ack), 1);

    // Weight write coinciding with an event uses the old weight.
    do_reset();
    drive(1'b0, 1'b1, 8'd20);
    drive(1'b1, 1'b1, 8'd50);
    check("old_weight", int'(current), 20);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    check("new_weight", int'(current), 70);

    // Events two cycles apart, then one after the window expires.
    do_reset();
    drive(1'b0, 1'b1, 8'd30);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
`ifdef SPIKE_SYNAPSE_REFRACTORY_EN
    check("refract_drop", int'(current), 30);
    check("refract_drop_ack", int'(spike_ack), 0);
`else
    check("no_refract_second", int'(current), 60);
    check("no_refract_ack", int'(spike_ack), 1);
`endif
    idle(2);
    drive(1'b1, 1'b0, 8'd0);
`ifdef SPIKE_SYNAPSE_REFRACTORY_EN
    check("refract_expired", int'(current), 60);
`else
    check("no_refract_third", int'(current), 90);
`endif
    check("third_event_ack", int'(spike_ack), 1);

    // Reset mid-operation with spike_in held high across release.
    do_reset();
    drive(1'b0, 1'b1, 8'd200);
    drive(1'b1, 1'b0, 8'd0);
    check("pre_reset_current", int'(current), 200);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_clears_current", int'(current), 0);
    check("reset_clears_ack", int'(spike_ack), 0);
    check("reset_clears_sat", int'(sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("event_after_release", int'(spike_ack), 1);
    check("zero_weight_after_reset", int'(current), 0);
    spike_in = 1'b0;
    idle(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
